// File: rtl/pdes_pkg.sv
// Shared definitions for the PDES PHOLD event scheduler.
//   - run-state encoding
//   - message field offset helpers (time / LP id / anti flag)
//   - null-message builder (anti=1, LP=0, time=0)
package pdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } sched_st_e;

  // Widest message the null builder supports; callers slice down to MSG_WID.
  localparam int MSG_MAX = 256;

  function automatic int time_lsb(input int tw, input int nlp);
    time_lsb = 0;
  endfunction

  function automatic int lp_lsb(input int tw, input int nlp);
    lp_lsb = tw;
  endfunction

  function automatic int anti_bit(input int tw, input int nlp);
    anti_bit = tw + $clog2(nlp);
  endfunction

  function automatic logic [MSG_MAX-1:0] null_msg(input int tw, input int nlp);
    null_msg = '0;
    null_msg[anti_bit(tw, nlp)] = 1'b1;
  endfunction

endpackage

// File: rtl/pdes_evt_sched_rr_arb.sv
// rr_arb_n: N-way round-robin arbiter.
//   req  : request vector
//   adv  : allow the pointer to move past the current winner
//   gnt  : one-hot grant, idx : grant index, any : some request granted
// Priority starts at the pointer; after a granted cycle with adv high the
// pointer moves to winner+1 (wraps naturally, N is a power of 2).
module rr_arb_n #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + k[IW-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr <= '0;
    else if (adv && any) ptr <= idx + 1'b1;
  end

endmodule

// File: rtl/pdes_evt_sched.sv
// pdes_evt_sched: run controller for the PDES PHOLD engine.
//   start/sim_end_time         : run control; rtn_vld pulses in FINISHED
//   core_evt_vld/data, core_ack: new events offered by cores (RR receive)
//   core_ready, core_disp_vld  : queue-head dispatch to ready cores (RR)
//   q_*                        : external priority queue
//   min_time(_vld), gvt        : monitor min time, monotonic GVT
//   stat_*                     : counters, built only with PDES_EVT_SCHED_STATS_EN
// One queue op per cycle: receive beats dispatch unless the queue is full,
// in which case offers are left pending so dispatch can drain the queue.
module pdes_evt_sched
  import pdes_pkg::*;
#(
  parameter int NUM_CORE = 4,
  parameter int NUM_LP   = 8,
  parameter int TIME_WID = 16,
  parameter int MSG_WID  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [TIME_WID-1:0]          sim_end_time,
  input  logic [NUM_CORE-1:0]          core_evt_vld,
  input  logic [NUM_CORE*MSG_WID-1:0]  core_evt_data,
  output logic [NUM_CORE-1:0]          core_ack,
  input  logic [NUM_CORE-1:0]          core_ready,
  output logic [NUM_CORE-1:0]          core_disp_vld,
  output logic [MSG_WID-1:0]           disp_data,
  output logic                         q_enq,
  output logic [MSG_WID-1:0]           q_din,
  output logic                         q_deq,
  input  logic [MSG_WID-1:0]           q_dout,
  input  logic                         q_full,
  input  logic                         q_empty,
  input  logic [TIME_WID-1:0]          min_time,
  input  logic                         min_time_vld,
  output logic [TIME_WID-1:0]          gvt,
  output logic                         rtn_vld,
  output logic [31:0]                  stat_disp_cnt,
  output logic [31:0]                  stat_null_cnt
);

  localparam int LPW = $clog2(NUM_LP);
  localparam int CW  = $clog2(NUM_CORE);
  localparam int TL  = time_lsb(TIME_WID, NUM_LP);
  localparam int LL  = lp_lsb(TIME_WID, NUM_LP);
  localparam int AB  = anti_bit(TIME_WID, NUM_LP);
  localparam logic [MSG_MAX-1:0] NULL_W = null_msg(TIME_WID, NUM_LP);

  sched_st_e          st;
  logic [LPW-1:0]     init_cnt;
  logic               running, initing;
  logic [NUM_CORE-1:0] rx_req, rx_gnt, dx_req, dx_gnt;
  logic [CW-1:0]      rx_idx, dx_idx;
  logic               rx_any, dx_any;
  logic [MSG_WID-1:0] evt, seed;
  logic               is_null;
  logic [TIME_WID-1:0] head_t, cand;
  logic               cand_vld;

  assign running = (st == ST_RUN);
  assign initing = (st == ST_INIT);

  // Full queue masks receive entirely so dispatch can make progress.
  assign rx_req = core_evt_vld & {NUM_CORE{running && !q_full}};
  assign dx_req = core_ready & {NUM_CORE{running && !rx_any && !q_empty}};

  rr_arb_n #(.N(NUM_CORE)) u_rx_arb (
    .clk(clk), .rst_n(rst_n), .req(rx_req), .adv(running),
    .gnt(rx_gnt), .idx(rx_idx), .any(rx_any)
  );

  rr_arb_n #(.N(NUM_CORE)) u_dx_arb (
    .clk(clk), .rst_n(rst_n), .req(dx_req), .adv(running),
    .gnt(dx_gnt), .idx(dx_idx), .any(dx_any)
  );

  assign evt     = core_evt_data[rx_idx*MSG_WID +: MSG_WID];
  assign is_null = (evt[AB:0] == NULL_W[AB:0]);

  always_comb begin
    seed = '0;
    seed[LL +: LPW] = init_cnt;
  end

  assign core_ack      = rx_gnt;
  assign core_disp_vld = dx_gnt;
  assign q_deq         = dx_any;
  assign disp_data     = q_dout;
  assign q_enq         = initing ? !q_full : (rx_any && !is_null);
  assign q_din         = initing ? seed : evt;

  // GVT candidate: min of the valid sources among monitor min and queue head.
  assign head_t   = q_dout[TL +: TIME_WID];
  assign cand_vld = min_time_vld || !q_empty;
  always_comb begin
    if (min_time_vld && !q_empty) cand = (min_time < head_t) ? min_time : head_t;
    else if (min_time_vld)        cand = min_time;
    else                          cand = head_t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      init_cnt <= '0;
      gvt      <= '0;
      rtn_vld  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          st       <= ST_INIT;
          init_cnt <= '0;
          gvt      <= '0;
        end
        ST_INIT: if (q_enq) begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LPW'(NUM_LP - 1)) st <= ST_RUN;
        end
        ST_RUN: begin
          if (cand_vld && cand > gvt) gvt <= cand;
          // Compares the registered gvt, so the end check lags one cycle.
          if (gvt > sim_end_time) begin
            st      <= ST_FIN;
            rtn_vld <= 1'b1;
          end
        end
        ST_FIN: begin
          st      <= ST_IDLE;
          rtn_vld <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef PDES_EVT_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_disp_cnt <= '0;
      stat_null_cnt <= '0;
    end else if (st == ST_IDLE && start) begin
      stat_disp_cnt <= '0;
      stat_null_cnt <= '0;
    end else begin
      if (q_deq)             stat_disp_cnt <= stat_disp_cnt + 1'b1;
      if (rx_any && is_null) stat_null_cnt <= stat_null_cnt + 1'b1;
    end
  end
`else
  assign stat_disp_cnt = '0;
  assign stat_null_cnt = '0;
`endif

endmodule

// File: doc/pdes_evt_sched.md
Name: pdes_evt_sched

Overview:
- Parametrised event scheduler/controller for the PDES PHOLD engine.
- Owns the run state machine, initial-event seeding, round-robin collection of new events from NUM_CORE cores, dispatch of queue-head events to ready cores, null-message filtering and monotonic GVT tracking.
- Sits between the core array, the external priority queue and the core monitor.
- Differs from the fixed 4-core/8-LP predecessor in three ways: core and LP counts are parametrised, the end time is runtime-programmable, and it handles queue-full backpressure.

Parameters:
- NUM_CORE, 4, number of cores (power of 2, 2..16)
- NUM_LP, 8, number of logical processes seeded at INIT (power of 2)
- TIME_WID, 16, timestamp width
- MSG_WID, 32, event message width (must be >= TIME_WID+$clog2(NUM_LP)+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leave IDLE
- sim_end_time  in  TIME_WID  run ends when gvt > this value
- core_evt_vld  in  NUM_CORE  core offers a new event
- core_evt_data  in  NUM_CORE*MSG_WID  per-core event, core i at [i*MSG_WID +: MSG_WID]
- core_ack  out  NUM_CORE  one-hot; offered event taken this cycle
- core_ready  in  NUM_CORE  core can accept an event
- core_disp_vld  out  NUM_CORE  one-hot dispatch strobe
- disp_data  out  MSG_WID  dispatched event (equals q_dout)
- q_enq  out  1  queue enqueue
- q_din  out  MSG_WID  queue write data
- q_deq  out  1  queue dequeue
- q_dout  in  MSG_WID  queue head
- q_full  in  1  queue full
- q_empty  in  1  queue empty
- min_time  in  TIME_WID  min in-flight timestamp from the monitor
- min_time_vld  in  1  min_time meaningful
- gvt  out  TIME_WID  global virtual time
- rtn_vld  out  1  one-cycle done pulse
- stat_disp_cnt  out  32  events dispatched (see Optional Feature)
- stat_null_cnt  out  32  null messages dropped (see Optional Feature)

Behaviour:
- Message fields: time [TIME_WID-1:0]; LP id [TIME_WID +: LPW], LPW=$clog2(NUM_LP); anti flag at bit TIME_WID+LPW. Null message = anti 1, LP 0, time 0.
- Reset: state IDLE; gvt 0; rtn_vld 0; RR pointers 0; init counter 0; stats 0. All strobes are combinational and 0 outside INIT/RUNNING.
- FSM transitions:
  - IDLE -> INIT on start.
  - INIT -> RUNNING after NUM_LP seeds are enqueued.
  - RUNNING -> FINISHED when gvt > sim_end_time.
  - FINISHED -> IDLE unconditionally. rtn_vld is 1 during the FINISHED cycle only (registered).
- INIT:
  - q_enq=!q_full; q_din={anti 0, LP=cnt, time 0}.
  - Counter increments only on an actual enq.
  - q_full pauses seeding with no skip or duplicate.
  - No core_ack or dispatch in INIT.
- RUNNING, one queue operation per cycle:
  - Receive: if any core_evt_vld and !q_full, an RR arbiter grants core g. core_ack[g]=1 and the event is consumed.
    - q_enq=1 unless the event is null; a null event is acked but not enqueued.
    - The RR pointer moves to g+1 (mod NUM_CORE) on grant.
  - Dispatch: only if no receive grant this cycle, !q_empty and any core_ready. The RR arbiter picks ready core d; q_deq=1, core_disp_vld[d]=1, disp_data=q_dout, and the pointer moves to d+1.
  - If q_full and cores are offering, receive is blocked (no ack), so dispatch may proceed. This prevents deadlock.
- GVT, registered, RUNNING only:
  - Candidate = min(min_time if min_time_vld, head time if !q_empty). If neither source is valid, gvt holds.
  - gvt <= max(gvt, candidate); gvt never decreases.
  - FINISHED check uses the registered gvt, giving 1-cycle latency.
- gvt holds through FINISHED/IDLE. gvt is cleared to 0 on the start pulse.
- start is ignored outside IDLE.
- Asynchronous reset mid-run returns to IDLE immediately and aborts any pending strobes.

Optional Feature:
- Macro: PDES_EVT_SCHED_STATS_EN.
- Defined:
  - stat_disp_cnt increments on each q_deq in RUNNING.
  - stat_null_cnt increments on each acked null.
  - Both counters are 32-bit wrapping, cleared by reset and by start.
- Undefined: the counters are not built and both ports are tied to 0.

Decomposition:
- Shared package pdes_pkg holds:
  - FSM state encoding (IDLE, INIT, RUNNING, FINISHED).
  - Message field offset functions: time_lsb, lp_lsb, anti_bit (from TIME_WID, NUM_LP).
  - The null-message constant builder.
- Sub-module rr_arb_n (parametrised N, req/adv -> one-hot grant, index, any). It is instantiated twice: receive and dispatch.

Test Plan:
- Seeding: NUM_LP=8, start -> exactly 8 q_enq with LP 0..7, time 0. Then RUNNING with q_full low throughout.
- Seeding with backpressure: q_full held high for cycles 3-5 of INIT -> seeding pauses and resumes. Still 8 enqs, LP order 0..7 with no duplicate.
- Receive fairness: all 4 cores offer continuously -> ack order 0,1,2,3,0. A null message (anti=1, LP 0, t=0) from core 2 -> acked, q_enq=0.
- Receive priority and full override: core 1 offers while core 3 is ready and the queue is non-empty -> receive wins. With q_full=1 the same cycle dispatches to core 3 instead.
- GVT monotonicity: min_time=40, head=30 -> gvt=30. Then min_time=20 -> gvt stays 30. Then both sources invalid -> gvt holds.
- End of run: sim_end_time=100, head time stepping to 101 -> gvt=101 next cycle, then FINISHED with a 1-cycle rtn_vld, then IDLE. Reset asserted mid-RUNNING -> all outputs at reset values.
